// File: rtl/pixel_write_master.sv
// Avalon-MM write master: stores RGB565 fragments into the back buffer and performs full-buffer clears.
// Optional macro BOUNDS_CHECK_EN discards off-screen fragments and counts them in dropped_count.
module pixel_write_master #(
    parameter int H_RESOLUTION = 256,
    parameter int V_RESOLUTION = 192
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] buffer_base,
    input  logic        clear_start,
    input  logic [15:0] clear_color,
    output logic        busy,
    output logic        done,
    input  logic        frag_valid,
    output logic        frag_ready,
    input  logic [15:0] frag_x,
    input  logic [15:0] frag_y,
    input  logic [15:0] frag_color,
    output logic [31:0] m_address,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    output logic        m_write,
    input  logic        m_waitrequest,
    output logic [15:0] dropped_count
);

    localparam logic [31:0] H_RES     = 32'(H_RESOLUTION);
    localparam logic [31:0] LAST_WORD = 32'((H_RESOLUTION * V_RESOLUTION) / 2 - 1);

    typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;

    state_t      state, state_d;
    logic        m_write_d, done_d;
    logic [31:0] m_address_d, m_writedata_d;
    logic [3:0]  m_byteenable_d;
    logic [31:0] word_cnt, word_cnt_d;

    logic [31:0] pix, byte_addr;
    logic        clear_go, slot_free, accept, oob;

    assign pix       = 32'(frag_y) * H_RES + 32'(frag_x);
    assign byte_addr = buffer_base + (pix << 1);

    // A clear only starts from a fully quiet master and beats a same-cycle fragment.
    assign clear_go   = clear_start && (state == IDLE) && !m_write;
    assign slot_free  = !m_write || !m_waitrequest;
    assign frag_ready = (state != CLEAR) && slot_free && !clear_go;
    assign accept     = frag_valid && frag_ready;
    assign busy       = (state != IDLE) || m_write;

`ifdef BOUNDS_CHECK_EN
    logic [15:0] dropped_q;

    assign oob = (32'(frag_x) >= H_RES) || (32'(frag_y) >= 32'(V_RESOLUTION));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dropped_q <= '0;
        end else if (accept && oob && (dropped_q != 16'hFFFF)) begin
            dropped_q <= dropped_q + 16'd1;
        end
    end

    assign dropped_count = dropped_q;
`else
    assign oob           = 1'b0;
    assign dropped_count = '0;
`endif

    always_comb begin
        state_d        = state;
        m_write_d      = m_write;
        m_address_d    = m_address;
        m_writedata_d  = m_writedata;
        m_byteenable_d = m_byteenable;
        word_cnt_d     = word_cnt;
        done_d         = 1'b0;
        case (state)
            IDLE, STREAM: begin
                if (clear_go) begin
                    state_d        = CLEAR;
                    m_write_d      = 1'b1;
                    m_address_d    = buffer_base;
                    m_writedata_d  = {clear_color, clear_color};
                    m_byteenable_d = 4'b1111;
                    word_cnt_d     = '0;
                end else begin
                    if (m_write && !m_waitrequest) begin
                        m_write_d = 1'b0;
                        state_d   = IDLE;
                    end
                    if (accept && !oob) begin
                        state_d        = STREAM;
                        m_write_d      = 1'b1;
                        m_address_d    = byte_addr & ~32'd3;
                        m_writedata_d  = {frag_color, frag_color};
                        m_byteenable_d = byte_addr[1] ? 4'b1100 : 4'b0011;
                    end
                end
            end
            CLEAR: begin
                // Colour stays in m_writedata; only the address walks.
                if (!m_waitrequest) begin
                    if (word_cnt == LAST_WORD) begin
                        m_write_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        word_cnt_d  = word_cnt + 32'd1;
                        m_address_d = m_address + 32'd4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
            word_cnt     <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_d;
            m_write      <= m_write_d;
            m_address    <= m_address_d;
            m_writedata  <= m_writedata_d;
            m_byteenable <= m_byteenable_d;
            word_cnt     <= word_cnt_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_write_master.sv
// Randomised bench for pixel_write_master: an expected-write queue built from accepted fragments and clears.
module tb_pixel_write_master;

    localparam int H     = 256;
    localparam int V     = 192;
    localparam int WORDS = H * V / 2;

    logic        clock, reset_n;
    logic [31:0] buffer_base;
    logic        clear_start;
    logic [15:0] clear_color;
    logic        busy, done;
    logic        frag_valid, frag_ready;
    logic [15:0] frag_x, frag_y, frag_color;
    logic [31:0] m_address, m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_write, m_waitrequest;
    logic [15:0] dropped_count;

    pixel_write_master #(.H_RESOLUTION(H), .V_RESOLUTION(V)) dut (
        .clock(clock), .reset_n(reset_n), .buffer_base(buffer_base),
        .clear_start(clear_start), .clear_color(clear_color), .busy(busy), .done(done),
        .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y),
        .frag_color(frag_color), .m_address(m_address), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .dropped_count(dropped_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          clr;
        bit          last;
    } wr_t;

    function automatic wr_t frag_write(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] c);
        wr_t r;
        logic [31:0] b;
        b    = base + 2 * ({16'd0, y} * H + {16'd0, x});
        r.a  = {b[31:2], 2'b00};
        r.d  = {c, c};
        r.be = b[1] ? 4'b1100 : 4'b0011;
        r.clr  = 1'b0;
        r.last = 1'b0;
        return r;
    endfunction

    function automatic bit off_screen(input logic [15:0] x, input logic [15:0] y);
`ifdef BOUNDS_CHECK_EN
        return (x >= H) || (y >= V);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model state
    wr_t         q[$];
    bit          clear_active = 0;
    bit          done_exp = 0;
    logic [15:0] exp_dropped = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_a, prev_d;
    logic [3:0]  prev_be;
    int          writes_done = 0;
    int          clear_wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] last_clear_addr = 0;

    always @(negedge clock) begin
        wr_t e;
        bit  honour, done_next, exp_ready;
        done_next = 0;
        if (!reset_n) begin
            check("rst_m_write", m_write, 0);
            check("rst_m_address", m_address, 0);
            check("rst_m_writedata", m_writedata, 0);
            check("rst_m_byteenable", m_byteenable, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_dropped", dropped_count, 0);
            q.delete();
            clear_active = 0;
            done_exp     = 0;
            exp_dropped  = 0;
            prev_stall   = 0;
        end else begin
            if (done) done_cnt++;
            check("m_write", m_write, q.size() != 0);
            check("busy", busy, clear_active || (q.size() != 0));
            check("done", done, done_exp);
            check("dropped_count", dropped_count, exp_dropped);
            honour    = clear_start && !clear_active && (q.size() == 0);
            exp_ready = !clear_active && ((q.size() == 0) || !m_waitrequest) && !honour;
            check("frag_ready", frag_ready, exp_ready);
            if (prev_stall) begin
                check("stable_address", m_address, prev_a);
                check("stable_writedata", m_writedata, prev_d);
                check("stable_byteenable", m_byteenable, prev_be);
            end
            if (m_write && !m_waitrequest && (q.size() != 0)) begin
                e = q.pop_front();
                check("wr_address", m_address, e.a);
                check("wr_writedata", m_writedata, e.d);
                check("wr_byteenable", m_byteenable, e.be);
                writes_done++;
                if (e.clr) begin
                    clear_wr_cnt++;
                    last_clear_addr = m_address;
                end
                if (e.last) begin
                    clear_active = 0;
                    done_next    = 1;
                end
            end
            if (frag_valid && frag_ready) begin
                if (off_screen(frag_x, frag_y)) begin
                    if (exp_dropped != 16'hFFFF) exp_dropped++;
                end else begin
                    q.push_back(frag_write(buffer_base, frag_x, frag_y, frag_color));
                end
            end
            if (honour) begin
                clear_active = 1;
                for (int i = 0; i < WORDS; i++) begin
                    e.a    = buffer_base + 32'(i) * 4;
                    e.d    = {clear_color, clear_color};
                    e.be   = 4'b1111;
                    e.clr  = 1'b1;
                    e.last = (i == WORDS - 1);
                    q.push_back(e);
                end
            end
            done_exp   = done_next;
            prev_stall = m_write && m_waitrequest;
            prev_a     = m_address;
            prev_d     = m_writedata;
            prev_be    = m_byteenable;
        end
    end

    // Slave stall generator: 0 never, 1 random, 2 scripted stall on one write, 3 always
    int mode = 0;
    int stall_idx = 0;
    int stall_left = 0;
    always @(posedge clock) begin
        #1;
        case (mode)
            0: m_waitrequest = 1'b0;
            1: m_waitrequest = ($urandom_range(0, 99) < 30);
            2: begin
                if (m_write && (writes_done == stall_idx) && (stall_left > 0)) begin
                    m_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    m_waitrequest = 1'b0;
                end
            end
            default: m_waitrequest = 1'b1;
        endcase
    end

    task automatic send_frag(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] c);
        bit ok;
        ok          = 0;
        buffer_base = base;
        frag_x      = x;
        frag_y      = y;
        frag_color  = c;
        frag_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (frag_ready) ok = 1;
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        frag_valid = 1'b0;
    endtask

    task automatic pulse_clear(input logic [31:0] base, input logic [15:0] c);
        buffer_base = base;
        clear_color = c;
        clear_start = 1'b1;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget);
        for (int i = 0; i < budget && done_cnt == start_cnt; i++) @(posedge clock);
        #1;
        check("clear_done_count", done_cnt - start_cnt, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int      d0, w0;
        logic [31:0] tmp;
        reset_n       = 1'b0;
        buffer_base   = 32'h0800_0000;
        clear_start   = 1'b0;
        clear_color   = 16'h0000;
        frag_valid    = 1'b0;
        frag_x        = 0;
        frag_y        = 0;
        frag_color    = 0;
        m_waitrequest = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single fragment at (3,2)
        send_frag(32'h0800_0000, 16'd3, 16'd2, 16'hF800);
        check("lit_single_write", m_write, 1);
        check("lit_single_addr", m_address, 32'h0800_0404);
        check("lit_single_be", m_byteenable, 4'b1100);
        check("lit_single_data", m_writedata, 32'hF800F800);
        @(posedge clock);
        #1;
        check("lit_single_one_cycle", m_write, 0);

        // Bounds corners
        send_frag(32'h0800_0000, 16'd256, 16'd0, 16'h1234);
        send_frag(32'h0800_0000, 16'd0, 16'd192, 16'h4321);
        send_frag(32'h0800_0000, 16'd255, 16'd191, 16'h07E0);
`ifdef BOUNDS_CHECK_EN
        check("lit_bounds_addr", m_address, 32'h0801_7FFC);
        check("lit_bounds_be", m_byteenable, 4'b1100);
        repeat (2) @(posedge clock);
        #1;
        check("lit_bounds_dropped", dropped_count, 2);
`endif
        repeat (2) @(posedge clock);
        #1;

        // Four back-to-back fragments, 3-cycle stall on the second write
        w0         = writes_done;
        stall_idx  = writes_done + 1;
        stall_left = 3;
        mode       = 2;
        send_frag(32'h0800_0000, 16'd0, 16'd0, 16'h1111);
        send_frag(32'h0800_0000, 16'd1, 16'd0, 16'h2222);
        send_frag(32'h0800_0000, 16'd10, 16'd5, 16'h3333);
        send_frag(32'h0800_0100, 16'd7, 16'd9, 16'h4444);
        repeat (8) @(posedge clock);
        #1;
        mode = 0;
        check("lit_b2b_count", writes_done - w0, 4);

        // clear_start while a fragment write is stalled is ignored
        mode = 3;
        @(posedge clock);
        #1;
        d0 = done_cnt;
        send_frag(32'h0800_0000, 16'd4, 16'd4, 16'hBEEF);
        pulse_clear(32'h0800_0000, 16'hFFFF);
        mode = 0;
        repeat (3) @(posedge clock);
        #1;
        check("lit_pending_no_done", done_cnt - d0, 0);
        check("lit_pending_idle", m_write, 0);

        // Full clear with a stray clear_start and fragment offered mid-clear
        clear_wr_cnt = 0;
        d0           = done_cnt;
        pulse_clear(32'h0800_0000, 16'h001F);
        repeat (10) @(posedge clock);
        #1;
        pulse_clear(32'h0900_0000, 16'hAAAA);
        frag_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        frag_valid = 1'b0;
        wait_done(d0, 30000);
        check("lit_clear_writes", clear_wr_cnt, WORDS);
        check("lit_clear_last_addr", last_clear_addr, 32'h0801_7FFC);
        repeat (2) @(posedge clock);
        #1;

        // Reset at clear word ~100 with the slave stalled
        clear_wr_cnt = 0;
        d0           = done_cnt;
        pulse_clear(32'h1000_0000, 16'h5555);
        for (int i = 0; i < 1000 && clear_wr_cnt < 100; i++) @(posedge clock);
        #1;
        mode = 3;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("lit_reset_m_write", m_write, 0);
        check("lit_reset_busy", busy, 0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        mode    = 0;
        repeat (3) @(posedge clock);
        #1;
        check("lit_reset_no_done", done_cnt - d0, 0);

        // Restart from word 0 with a base that wraps past 2^32
        clear_wr_cnt = 0;
        d0           = done_cnt;
        pulse_clear(32'hFFFF_C000, 16'hA5A5);
        check("lit_restart_addr", m_address, 32'hFFFF_C000);
        check("lit_restart_data", m_writedata, 32'hA5A5A5A5);
        wait_done(d0, 30000);
        check("lit_wrap_last_addr", last_clear_addr, 32'h0001_3FFC);
        repeat (2) @(posedge clock);
        #1;

        // Random fragments against random slave stalls
        mode = 1;
        for (int i = 0; i < 800; i++) begin
            frag_valid  = ($urandom_range(0, 9) < 7);
            frag_x      = 16'($urandom_range(0, 300));
            frag_y      = 16'($urandom_range(0, 220));
            frag_color  = 16'($urandom);
            tmp         = $urandom;
            buffer_base = tmp & ~32'd3;
            clear_start = m_write && ($urandom_range(0, 9) == 0);
            clear_color = 16'($urandom);
            @(posedge clock);
            #1;
        end
        frag_valid  = 1'b0;
        clear_start = 1'b0;
        mode        = 0;
        repeat (6) @(posedge clock);
        #1;
        check("drain_empty", q.size(), 0);
        check("drain_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_write_master.md
Name: pixel_write_master

Overview:
- Avalon-MM write master that turns rasterised fragments into 16-bit RGB565 stores in the back pixel buffer.
- Also provides a hardware clear that fills the whole buffer with one colour.
- Sits directly downstream of the GPU register block. That block supplies the back-buffer base address; this block drives the GPU's m1 master port.

Parameters:
- H_RESOLUTION, 256, pixels per row.
- V_RESOLUTION, 192, rows per frame. H_RESOLUTION*V_RESOLUTION must be even.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- buffer_base  in  32  back-buffer byte address (register 0x01 of GPU), word-aligned.
- clear_start  in  1  single-cycle pulse; begin full-buffer clear.
- clear_color  in  16  RGB565 fill colour, sampled with clear_start.
- busy  out  1  high while a clear runs or a write is pending.
- done  out  1  one-cycle pulse when a clear completes.
- frag_valid  in  1  fragment present.
- frag_ready  out  1  fragment accepted when valid&ready.
- frag_x  in  16  pixel column.
- frag_y  in  16  pixel row.
- frag_color  in  16  RGB565 colour.
- m_address  out  32  Avalon byte address, always word-aligned.
- m_writedata  out  32  write data.
- m_byteenable  out  4  byte lanes.
- m_write  out  1  write request.
- m_waitrequest  in  1  slave stall.
- dropped_count  out  16  out-of-bounds fragment count (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): state IDLE; m_write=0; m_address=0; m_writedata=0; m_byteenable=0; busy=0; done=0; dropped_count=0. Takes effect immediately, including mid-clear or mid-write; the pending write is abandoned.
- FSM has three states: IDLE, STREAM, CLEAR.
- Avalon rule: once m_write=1, m_address, m_writedata and m_byteenable hold stable until a cycle with m_waitrequest=0. The write completes on that edge.
- Fragment path (IDLE/STREAM):
  - frag_ready = (state!=CLEAR) && (!m_write || !m_waitrequest). This is a one-entry output register, giving 1 fragment/cycle when the slave never stalls.
  - On accept: pix = frag_y*H_RESOLUTION + frag_x (32-bit); byte = buffer_base + (pix<<1).
  - m_address = byte & ~3; m_writedata = {frag_color, frag_color}; m_byteenable = byte[1] ? 4'b1100 : 4'b0011.
  - m_write=1 on the next cycle; latency is 1 clock from accept to m_write.
  - buffer_base is sampled at accept.
  - If the write completes with no new fragment, m_write drops to 0 and the state returns to IDLE.
- Clear path:
  - clear_start is honoured only in IDLE with m_write=0. Otherwise it is ignored: no queueing, no done pulse.
  - On clear_start: latch buffer_base and clear_color; word counter = 0; state CLEAR; frag_ready=0.
  - Each write: m_address = base + (counter<<2); m_writedata = {color, color}; m_byteenable = 4'b1111; m_write held high continuously.
  - counter increments on each completed write.
  - After word (H_RESOLUTION*V_RESOLUTION/2 - 1) completes: m_write=0, done=1 for one cycle, state IDLE.
- busy = (state!=IDLE) || m_write.
- Simultaneous clear_start and frag_valid in IDLE: the clear wins and the fragment is not accepted.
- Address arithmetic is unsigned 32-bit and wraps modulo 2^32.

Optional Feature:
- Macro BOUNDS_CHECK_EN.
- When defined: a fragment with frag_x>=H_RESOLUTION or frag_y>=V_RESOLUTION is accepted (frag_ready behaviour unchanged) but generates no write. dropped_count increments, saturating at 16'hFFFF, and clears only on reset.
- When undefined: no check is made and all fragments are written with wrapped addresses; dropped_count is tied to 0.

Test Plan:
- Single fragment: buffer_base=0x0800_0000, x=3, y=2, color=0xF800, waitrequest=0 -> one cycle with m_write=1, m_address=0x0800_0404, m_byteenable=4'b1100, m_writedata=0xF800F800.
- Back-to-back with stall: 4 fragments, m_waitrequest high for 3 cycles on the 2nd write -> frag_ready low during the stall, outputs stable, exactly 4 writes in order, no loss or duplication.
- Clear: clear_color=0x001F -> exactly 24576 writes, addresses 0x0800_0000..0x0801_7FFC step 4, byteenable 4'b1111, one done pulse, frag_ready=0 throughout.
- clear_start asserted mid-clear and during a pending fragment write -> ignored; write count and done count unchanged.
- BOUNDS_CHECK_EN: fragments (256,0) and (0,192) -> no m_write, dropped_count=2; in-range (255,191) writes to 0x0801_7FFE (m_address 0x0801_7FFC, byteenable 4'b1100).
- reset_n low for one cycle at clear word 100 with waitrequest=1 -> m_write=0 immediately, busy=0, no done pulse; a new clear_start restarts at word 0.
